// File: rtl/fir_axis_sink_if.sv
// AXI-Stream sample channel between the FIR master port and its capture sink.
interface fir_axis_sink_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_axis_sink.sv
// Frame capture sink for the FIR output stream: buffers one frame, sums it,
// checks tlast framing and can throttle the source with an LFSR-gated tready.
module fir_axis_sink #(
  parameter int          DATA_WIDTH = 16,
  parameter int          xL         = 2048,
  parameter int          ADDR_WIDTH = 11,
  parameter int          STALL_MODE = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  fir_axis_sink_if.slave        s_axis,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   beat_count,
  output logic [31:0]           checksum,
  output logic                  done,
  output logic                  err_early_last,
  output logic                  err_missing_last,
  output logic                  err_overrun
);

  typedef enum logic {S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(xL - 1);

  state_t                state_q, state_d;
  logic [15:0]           lfsr;
  logic                  lfsr_fb;
  logic                  ready;
  logic                  accept;
  logic                  last_beat;
  logic                  set_early, set_missing, set_overrun;
  logic [31:0]           sample_sext;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10), new bit enters at bit 0
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    ready = 1'b0;
    if (state_q == S_CAPTURE)
      ready = (STALL_MODE == 0) ? 1'b1 : (lfsr[0] | lfsr[1]);
  end

  assign s_axis.tready = ready;
  // restart outranks a coincident handshake, so that beat is dropped
  assign accept      = s_axis.tvalid & ready & ~restart;
  assign last_beat   = (beat_count == LAST_IDX);
  assign sample_sext = {{(32-DATA_WIDTH){s_axis.tdata[DATA_WIDTH-1]}}, s_axis.tdata};
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    set_early   = 1'b0;
    set_missing = 1'b0;
    set_overrun = 1'b0;
    if (restart) begin
      state_d = S_CAPTURE;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (accept && (s_axis.tlast || last_beat)) begin
            state_d     = S_DONE;
            set_early   = s_axis.tlast & ~last_beat;
            set_missing = last_beat & ~s_axis.tlast;
          end
        end
        S_DONE: set_overrun = s_axis.tvalid;
        default: state_d = S_CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_CAPTURE;
      lfsr             <= LFSR_SEED;
      beat_count       <= '0;
      checksum         <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      err_overrun      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CAPTURE)
        lfsr <= {lfsr[14:0], lfsr_fb};
      if (restart) begin
        beat_count       <= '0;
        checksum         <= '0;
        err_early_last   <= 1'b0;
        err_missing_last <= 1'b0;
        err_overrun      <= 1'b0;
      end else begin
        if (accept) begin
          beat_count <= beat_count + 1'b1;
          checksum   <= checksum + sample_sext;
        end
        if (set_early)   err_early_last   <= 1'b1;
        if (set_missing) err_missing_last <= 1'b1;
        if (set_overrun) err_overrun      <= 1'b1;
      end
    end
  end

  // Buffer has no reset; a same-address read in the write cycle sees old data
  always_ff @(posedge clk) begin
    if (accept)
      mem[beat_count[ADDR_WIDTH-1:0]] <= s_axis.tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/fir_axis_sink.md
# fir_axis_sink

AXI-Stream sink that terminates the FIR filter's master output (`m_axis_fir_*`) in simulation and on-chip capture builds. It accepts one frame of `xL` samples, stores them in an internal buffer, keeps a running checksum, and checks that `tlast` lands on exactly the last beat. An optional LFSR-driven `tready` pattern applies backpressure to the filter's output pipeline.

## Interface
- `DATA_WIDTH`, 16, sample width (signed two's complement).
- `xL`, 2048, frame length in beats; must be ≥ 2.
- `ADDR_WIDTH`, 11, buffer address width; `2**ADDR_WIDTH` must be ≥ `xL`.
- `STALL_MODE`, 0, 0 = `tready` high whenever capturing; 1 = LFSR-gated `tready`.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `restart`  in  1  single-cycle pulse that re-arms capture; buffer contents are not cleared.
- `s_axis_tdata`  in  DATA_WIDTH  sample from the FIR master port.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tlast`  in  1  frame end marker.
- `s_axis_tready`  out  1  sink ready.
- `rd_addr`  in  ADDR_WIDTH  buffer readback address.
- `rd_data`  out  DATA_WIDTH  buffer readback data, registered.
- `beat_count`  out  ADDR_WIDTH+1  number of beats accepted in the current frame.
- `checksum`  out  32  wrapping sum of sign-extended accepted samples.
- `done`  out  1  frame finished (normally or on error).
- `err_early_last`  out  1  sticky: `tlast` arrived before beat `xL`.
- `err_missing_last`  out  1  sticky: beat `xL` arrived without `tlast`.
- `err_overrun`  out  1  sticky: `tvalid` was high while in DONE.

## Operation
- **States:** CAPTURE and DONE. Reset enters CAPTURE.
- **Reset values:** `beat_count`=0, `checksum`=0, `done`=0, all `err_*`=0, `rd_data`=0, LFSR=`LFSR_SEED`.
- **Acceptance:** a beat is accepted when `s_axis_tvalid & s_axis_tready`. On acceptance:
  - `mem[beat_count]` ← `tdata`;
  - `beat_count` increments;
  - `checksum` ← `checksum + sext32(tdata)`, mod 2^32.
- **`tready` in CAPTURE:**
  - `STALL_MODE`=0: `tready`=1.
  - `STALL_MODE`=1: `tready` = `lfsr[0] | lfsr[1]`, about 75% duty.
  - `tready` never depends on `tvalid`.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, shift-in at bit 0. It advances every cycle in CAPTURE and holds in DONE.
- **CAPTURE → DONE on an accepted beat n (1-based):**
  - `tlast`=1 and n < `xL`: set `err_early_last`.
  - n = `xL` and `tlast`=0: set `err_missing_last`.
  - n = `xL` and `tlast`=1: clean end, no error.
- **DONE:** `tready`=0 and `done`=1. Any cycle with `tvalid`=1 sets `err_overrun`. The block stays in DONE until `reset` or `restart`.
- **`restart`** (any state): go to CAPTURE; clear `beat_count`, `checksum`, `done` and all `err_*`. LFSR is not reseeded. If `restart` coincides with a beat handshake, `restart` wins and the beat is not accepted.
- **`reset`** has priority over `restart`. Reset in the middle of a frame discards the partial count; buffer contents are left undefined.
- **Readback:** `rd_data` ← `mem[rd_addr]` every cycle. A read and a write to the same address in the same cycle return the old data.

## Timing
- `beat_count`, `checksum` and the buffer write all update on the edge that accepts the beat.
- `done` and `err_early_last` / `err_missing_last` are visible the cycle after the terminating beat. `tready` falls in that same cycle.
- `err_overrun` is visible the cycle after the offending `tvalid`.
- `rd_data` has 1-cycle latency from `rd_addr`.
- Throughput with `STALL_MODE`=0 is 1 beat per cycle. A full frame completes in `xL` cycles of continuous `tvalid`.

## Test plan
- **Clean frame:** `STALL_MODE`=0, `xL`=8, samples 1..8 with `tlast` on beat 8.
  - Expect `done`=1 one cycle later, `beat_count`=8, `checksum`=36, no errors.
  - Readback of addr 0..7 returns 1..8.
- **Negative data:** samples 16'hFFFF ×4 (`xL`=4). Expect `checksum`=32'hFFFFFFFC.
- **Early `tlast`:** `tlast` on beat 5 of 8. Expect `err_early_last`=1, `beat_count`=5, `done`=1, `tready`=0.
- **Missing `tlast`:** 8 beats, none with `tlast`. Expect `err_missing_last`=1 after beat 8. A 9th `tvalid` sets `err_overrun`.
- **Backpressure:** `STALL_MODE`=1, `xL`=2048, source holds `tvalid`/`tdata` stable while stalled.
  - Expect all 2048 samples stored in order, `checksum` equal to the reference sum, and `tready` deasserted for about 25% of cycles.
- **Re-arm:** `restart` pulse after `done`. Expect `beat_count`=0, `checksum`=0, flags cleared, `tready`=1; a second frame captures correctly.
